icb_arbiter_2to1: RTL
=====================

ICB_ARBITER_2TO1 -- requirements
Module: icb_arbiter_2to1

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, max accepted-but-unanswered commands (1..4).
REQ-002 SHALL have parameter AW, default `ICB_WIDTH, width of addr/wdata/rdata; wmask is AW/8.
REQ-003 SHALL have ports:
- clk  in  1  the one clock.
- rst_n  in  1  reset; synchronous, active-low.
- m_icb_cmd_valid  in  2  per-master command valid; bit N = master N.
- m_icb_cmd_ready  out  2  per-master command ready.
- m_icb_cmd_addr / m_icb_cmd_wdata  in  2*AW each  packed per-master address / write data.
- m_icb_cmd_read / m_icb_cmd_wmask  in  2 / 2*AW/8  per-master read flag / byte mask.
- m_icb_rsp_valid  out  2  per-master response valid.
- m_icb_rsp_ready  in  2  per-master response ready.
- m_icb_rsp_rdata / m_icb_rsp_err  out  2*AW / 2  per-master read data / error.
- s_icb_cmd_valid / s_icb_cmd_ready  out / in  1 each  slave command handshake.
- s_icb_cmd_addr, _read, _wdata, _wmask  out  AW, 1, AW, AW/8  slave command payload.
- s_icb_rsp_valid / s_icb_rsp_ready  in / out  1 each  slave response handshake.
- s_icb_rsp_rdata / s_icb_rsp_err  in  AW / 1  slave response payload.

Function
REQ-004 Handshake on any ICB channel SHALL be valid&ready in the same cycle; zero added latency on cmd and rsp paths (combinational forward).
REQ-005 Arbiter states: IDLE (no lock) and LOCK (grant held); lock register holds 1-bit grant id.
REQ-006 IDLE: grant = arbitration winner among valid masters; s_icb_cmd_valid = valid of winner, payload muxed from winner.
REQ-007 IDLE->LOCK when s_icb_cmd_valid & !s_icb_cmd_ready; LOCK holds grant until the slave cmd handshake, then ->IDLE; grant SHALL NOT change while LOCK.
REQ-008 m_icb_cmd_ready[N] = s_icb_cmd_ready & grant==N & !fifo_full; other master ready=0.
REQ-009 When route FIFO holds OUTSTANDING entries, s_icb_cmd_valid SHALL be 0 and no master ready.
REQ-010 Route FIFO (depth OUTSTANDING) SHALL push grant id on slave cmd handshake and pop on slave rsp handshake; same-cycle push+pop keeps count, legal when full.
REQ-011 Responses route to FIFO head id: m_icb_rsp_valid[head]=s_icb_rsp_valid; s_icb_rsp_ready=m_icb_rsp_ready[head]; rdata/err broadcast to both, valid only on head.
REQ-012 s_icb_rsp_valid with empty FIFO SHALL be ignored: s_icb_rsp_ready=0, no master rsp_valid.
REQ-013 FIFO pointers SHALL wrap modulo OUTSTANDING; count width $clog2(OUTSTANDING+1).

Reset
REQ-014 While rst_n=0 at clk edge: state IDLE, grant 0, FIFO count/pointers 0, RR pointer 0; outputs then s_icb_cmd_valid=0, all m_icb_cmd_ready=0 unless valid, m_icb_rsp_valid=0.
REQ-015 Reset mid-transaction SHALL drop lock and all outstanding routing; late slave responses are ignored per REQ-012.

Configuration
REQ-016 ICB_ARB_RR_EN defined: round-robin; RR pointer flips to the other master after each granted cmd handshake, contending masters served alternately.
REQ-017 ICB_ARB_RR_EN undefined: fixed priority, master 0 always wins; RR pointer not instantiated.

Structure
REQ-018 Package icb_arb_pkg SHALL hold arb_state_e {IDLE, LOCK}, master-id typedef, and OUTSTANDING_MAX=4.
REQ-019 Route FIFO SHALL be sub-module icb_arb_route_fifo (parameterised depth, 1-bit data, full/empty).

Verification
REQ-020 Both masters valid every cycle, slave always ready, RR_EN -> grants alternate 0,1,0,1; without RR_EN all to master 0.
REQ-021 M1 cmd addr=0x100, slave ready low 3 cycles while M0 raises valid -> slave addr stays 0x100, M1 handshake cycle 4, M0 next.
REQ-022 OUTSTANDING=2, slave withholds rsp -> after 2 cmds s_icb_cmd_valid=0; one rsp handshake -> third cmd issues next cycle.
REQ-023 Order M0,M1 cmds; slave rsp rdata 0xA5 then 0x5A with err=1 on second -> M0 gets 0xA5, M1 gets 0x5A with err=1.
REQ-024 rst_n low one cycle with 2 outstanding and slave locked -> next cycle FIFO empty, IDLE, stray slave rsp not forwarded.

Source files
------------

// File: rtl/icb_arb_pkg.sv
// Shared types for the 2:1 ICB arbiter (state encoding, master id, limits).
// Default data width comes from ICB_WIDTH; 32 when the build does not set it.
`ifndef ICB_WIDTH
`define ICB_WIDTH 32
`endif

package icb_arb_pkg;

   localparam int unsigned OUTSTANDING_MAX = 4;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   typedef logic mst_id_t;

endpackage

// File: rtl/icb_arb_route_fifo.sv
// Route FIFO: remembers which master owns each outstanding command, oldest first.
module icb_arb_route_fifo
   import icb_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  mst_id_t push_id,
   input  logic    pop,
   output mst_id_t head_id,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   mst_id_t        mem [2**PW];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage, pointers and occupancy; push+pop together leaves count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   assign head_id = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/icb_arbiter_2to1.sv
// Two-master to one-slave ICB arbiter with response routing.
// ICB_ARB_RR_EN: round-robin between contending masters; otherwise master 0 wins.
module icb_arbiter_2to1
   import icb_arb_pkg::*;
#(
   parameter int unsigned OUTSTANDING = 2,
   parameter int unsigned AW          = `ICB_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            m_icb_cmd_valid,
   output logic [1:0]            m_icb_cmd_ready,
   input  logic [2*AW-1:0]       m_icb_cmd_addr,
   input  logic [1:0]            m_icb_cmd_read,
   input  logic [2*AW-1:0]       m_icb_cmd_wdata,
   input  logic [2*(AW/8)-1:0]   m_icb_cmd_wmask,
   output logic [1:0]            m_icb_rsp_valid,
   input  logic [1:0]            m_icb_rsp_ready,
   output logic [2*AW-1:0]       m_icb_rsp_rdata,
   output logic [1:0]            m_icb_rsp_err,
   output logic                  s_icb_cmd_valid,
   input  logic                  s_icb_cmd_ready,
   output logic [AW-1:0]         s_icb_cmd_addr,
   output logic                  s_icb_cmd_read,
   output logic [AW-1:0]         s_icb_cmd_wdata,
   output logic [AW/8-1:0]       s_icb_cmd_wmask,
   input  logic                  s_icb_rsp_valid,
   output logic                  s_icb_rsp_ready,
   input  logic [AW-1:0]         s_icb_rsp_rdata,
   input  logic                  s_icb_rsp_err
);

   localparam int unsigned MW = AW / 8;

   arb_state_e state_q;
   arb_state_e state_d;
   mst_id_t    lock_q;
   mst_id_t    lock_d;
   mst_id_t    winner_c;
   mst_id_t    grant_c;
   mst_id_t    head_id;
   logic       cmd_hs;
   logic       rsp_hs;
   logic       fifo_full;
   logic       fifo_empty;

`ifdef ICB_ARB_RR_EN
   mst_id_t    rr_q;

   // Priority passes to the other master after every granted command.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else if (cmd_hs) begin
         rr_q <= ~grant_c;
      end
   end

   assign winner_c = (m_icb_cmd_valid == 2'b11) ? rr_q : 1'(m_icb_cmd_valid == 2'b10);
`else
   assign winner_c = 1'(m_icb_cmd_valid == 2'b10);
`endif

   // State and lock registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end

   // Grant selection, slave command valid, master readies and lock transitions.
   always_comb begin
      state_d         = state_q;
      lock_d          = lock_q;
      grant_c         = winner_c;
      m_icb_cmd_ready = 2'b00;

      if (state_q == LOCK) begin
         grant_c = lock_q;
      end

      s_icb_cmd_valid          = m_icb_cmd_valid[grant_c] & ~fifo_full;
      cmd_hs                   = s_icb_cmd_valid & s_icb_cmd_ready;
      m_icb_cmd_ready[grant_c] = s_icb_cmd_ready & ~fifo_full & m_icb_cmd_valid[grant_c];

      case (state_q)
         IDLE: begin
            if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
               state_d = LOCK;
               lock_d  = grant_c;
            end
         end
         LOCK: begin
            if (cmd_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command payload forwarded from the granted master.
   assign s_icb_cmd_addr  = grant_c ? m_icb_cmd_addr[2*AW-1:AW]  : m_icb_cmd_addr[AW-1:0];
   assign s_icb_cmd_wdata = grant_c ? m_icb_cmd_wdata[2*AW-1:AW] : m_icb_cmd_wdata[AW-1:0];
   assign s_icb_cmd_wmask = grant_c ? m_icb_cmd_wmask[2*MW-1:MW] : m_icb_cmd_wmask[MW-1:0];
   assign s_icb_cmd_read  = m_icb_cmd_read[grant_c];

   // Responses go to the master at the FIFO head; nothing is routed when empty.
   always_comb begin
      m_icb_rsp_valid          = 2'b00;
      m_icb_rsp_valid[head_id] = s_icb_rsp_valid & ~fifo_empty;
      s_icb_rsp_ready          = m_icb_rsp_ready[head_id] & ~fifo_empty;
      rsp_hs                   = s_icb_rsp_valid & s_icb_rsp_ready;
   end

   assign m_icb_rsp_rdata = {2{s_icb_rsp_rdata}};
   assign m_icb_rsp_err   = {2{s_icb_rsp_err}};

   icb_arb_route_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_route_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (cmd_hs),
      .push_id (grant_c),
      .pop     (rsp_hs),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule
